sdf_march_engine: RTL
=====================

SDF_MARCH_ENGINE -- requirements
Module: sdf_march_engine

Interface
REQ-001 SHALL have clock clk and reset rst_n (asynchronous, active-low); all state on posedge clk.
REQ-002 SHALL have parameters: N_ITER (default 6, march iterations per ray); EPS (default 16'h0040, hit threshold 1/64 in Q4.12); ESCAPE (default 16'h4000, 4.0 escape bound).
REQ-003 Ports, in order:
 clk  in  1  clock
 rst_n  in  1  async active-low reset
 start  in  1  single-cycle request; captures all ray inputs
 origin_x/y/z  in  16 each  signed ray origin, Q4.12 (1.0 = 0x1000)
 dir_x/y/z  in  16 each  signed unit direction, Q2.14 (1.0 = 0x4000)
 light_x/y/z  in  16 each  signed light direction, Q2.14
 busy  out  1  ray in flight
 done  out  1  one-cycle pulse when results update
 surface_hit  out  1  ray hit Kirby
 intensity  out  16  signed diffuse term, Q2.14
 feature_id  out  3  0 miss, 1 body, 2 foot, 3 eye

Function
REQ-004 SHALL run FSM IDLE -> MARCH (N_ITER cycles) -> SHADE (1 cycle) -> IDLE.
REQ-005 On start, SHALL register origin, dir and light, set busy, clear iteration counter and enter MARCH, from any state.
REQ-006 Latency: done SHALL pulse, and outputs SHALL update, exactly N_ITER+2 cycles after the start cycle (8 by default), independent of early hit or escape.
REQ-007 Outputs SHALL hold their values between done pulses; busy SHALL fall in the done cycle.
REQ-008 start during MARCH/SHADE SHALL abort the current ray with no done pulse for it and restart per REQ-005.
REQ-009 Per MARCH cycle: evaluate scene SDF d at p; if d <= EPS latch hit and freeze p; else p += (dir*d)>>>14 per component, three signed 16x16 multiplies, 32-bit products.
REQ-010 Length approximation: m = max(|a|,|b|,|c|); len = m + ((|a|+|b|+|c| - m) >>> 2); 18-bit internal, no overflow.
REQ-011 Scene: body sphere centre (0,0,0) radius 0x1000; feet spheres centre (+/-0x099A, -0x0E66, 0) radius 0x0800; d = min of the three; ties resolve body first.
REQ-012 Escape: any |p| component > ESCAPE SHALL latch miss and freeze p; miss wins over a later hit.
REQ-013 In SHADE, normal n = (p - c) << 2 (body) or << 3 (foot), saturated to 16 bits; intensity = (n.light)>>>14 saturated to [-0x8000, 0x7FFF], reusing the REQ-009 multipliers.
REQ-014 feature_id on hit: 3 if body hit with p_z < -0x0C00, 0x0400 <= |p_x| <= 0x0800, 0 <= p_y <= 0x0800; else 1 for body, 2 for foot.
REQ-015 No hit after N_ITER iterations, or escape: surface_hit 0, intensity 0, feature_id 0.

Reset
REQ-016 rst_n low SHALL force IDLE, busy 0, done 0, surface_hit 0, intensity 0, feature_id 0, and clear latched ray state; an in-flight ray is discarded with no done.

Structure
REQ-017 Shared package holds the Q-format constants, EPS/ESCAPE defaults, sphere centres/radii, eye-band bounds and feature_id encodings; the camera/ray generator uses the same package.
REQ-018 Scene-distance evaluation (REQ-010/011, returns d and nearest-object id) SHALL be one combinational sub-module, kirby_sdf.
REQ-019 Sustained rate: one ray per 16 cycles with zero backpressure.

Verification
REQ-020 origin (0,0,-0x3000), dir (0,0,0x4000), light (0,0,-0x4000) -> at start+8: done=1, hit=1, feature 1, intensity 0x4000.
REQ-021 Same origin, dir (0x4000,0,0) -> at start+8: hit=0, feature 0, intensity 0; busy high cycles +1..+7.
REQ-022 origin (0x099A,-0x0E66,-0x3000), dir (0,0,0x4000) -> hit=1, feature 2.
REQ-023 Second start 3 cycles after first -> exactly one done, at second start+8, carrying second ray's result.
REQ-024 rst_n pulsed low at start+4 -> all outputs 0 immediately, no done pulse; next start completes normally.
REQ-025 Starts every 16 cycles over 40 random rays -> each result matches a bit-exact reference model and is held stable until the next done.

Source files
------------

// File: rtl/sdf_march_engine_pkg.sv
// Shared constants and types for the Kirby sphere-tracing engine and the
// camera/ray generator: Q formats, thresholds, scene geometry, eye band and
// feature codes.
package sdf_march_engine_pkg;

    // Fixed-point formats: positions/distances Q4.12, directions/normals Q2.14
    localparam int Q_POS_FRAC = 12;
    localparam int Q_DIR_FRAC = 14;
    localparam logic signed [15:0] ONE_POS = 16'sh1000;
    localparam logic signed [15:0] ONE_DIR = 16'sh4000;

    // Marcher defaults
    localparam int          N_ITER_DEFAULT = 6;
    localparam logic [15:0] EPS_DEFAULT    = 16'h0040;
    localparam logic [15:0] ESCAPE_DEFAULT = 16'h4000;

    // Scene: body sphere at the origin, two feet mirrored in x
    localparam logic signed [15:0] BODY_R  = 16'sh1000;
    localparam logic signed [15:0] FOOT_CX = 16'sh099A;
    localparam logic signed [15:0] FOOT_CY = -16'sh0E66;
    localparam logic signed [15:0] FOOT_R  = 16'sh0800;

    // Eye band on the body surface (z strictly below EYE_Z_MAX)
    localparam logic signed [15:0] EYE_Z_MAX = -16'sh0C00;
    localparam logic signed [15:0] EYE_X_MIN = 16'sh0400;
    localparam logic signed [15:0] EYE_X_MAX = 16'sh0800;
    localparam logic signed [15:0] EYE_Y_MIN = 16'sh0000;
    localparam logic signed [15:0] EYE_Y_MAX = 16'sh0800;

    typedef enum logic [2:0] {
        FEAT_MISS = 3'd0,
        FEAT_BODY = 3'd1,
        FEAT_FOOT = 3'd2,
        FEAT_EYE  = 3'd3
    } feature_e;

    typedef enum logic [1:0] {
        OBJ_BODY   = 2'd0,
        OBJ_FOOT_R = 2'd1,
        OBJ_FOOT_L = 2'd2
    } obj_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARCH = 2'd1,
        ST_SHADE = 2'd2
    } state_e;

    // Centre coordinate of a scene object along axis 0 (x), 1 (y) or 2 (z)
    function automatic logic signed [15:0] obj_centre(input obj_e obj, input int axis);
        logic signed [15:0] c;
        c = 16'sh0000;
        case (obj)
            OBJ_FOOT_R: c = (axis == 0) ? FOOT_CX : ((axis == 1) ? FOOT_CY : 16'sh0000);
            OBJ_FOOT_L: c = (axis == 0) ? -FOOT_CX : ((axis == 1) ? FOOT_CY : 16'sh0000);
            default:    c = 16'sh0000;
        endcase
        return c;
    endfunction

    function automatic logic signed [15:0] obj_radius(input obj_e obj);
        return (obj == OBJ_BODY) ? BODY_R : FOOT_R;
    endfunction

    // Clamp a wide signed value into signed 16 bits
    function automatic logic signed [15:0] sat16(input logic signed [34:0] v);
        logic signed [15:0] r;
        if (v > 35'sd32767)
            r = 16'sh7FFF;
        else if (v < -35'sd32768)
            r = 16'sh8000;
        else
            r = v[15:0];
        return r;
    endfunction

endpackage

// File: rtl/kirby_sdf.sv
// Combinational scene distance: approximate Euclidean length to each sphere,
// minus its radius; returns the smallest (body wins ties) and which object.
module kirby_sdf
    import sdf_march_engine_pkg::*;
(
    input  logic signed [15:0] i_p_x,
    input  logic signed [15:0] i_p_y,
    input  logic signed [15:0] i_p_z,
    output logic signed [15:0] o_d,
    output obj_e               o_obj
);

    logic signed [18:0] w_dist [3];
    logic signed [18:0] w_best;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_obj
            localparam obj_e OBJ = obj_e'(gi);
            logic signed [16:0] w_dx, w_dy, w_dz;
            logic        [16:0] w_ax, w_ay, w_az, w_m;
            logic        [17:0] w_sum, w_len;

            assign w_dx = 17'(i_p_x) - 17'(obj_centre(OBJ, 0));
            assign w_dy = 17'(i_p_y) - 17'(obj_centre(OBJ, 1));
            assign w_dz = 17'(i_p_z) - 17'(obj_centre(OBJ, 2));

            assign w_ax = w_dx[16] ? $unsigned(-w_dx) : $unsigned(w_dx);
            assign w_ay = w_dy[16] ? $unsigned(-w_dy) : $unsigned(w_dy);
            assign w_az = w_dz[16] ? $unsigned(-w_dz) : $unsigned(w_dz);

            assign w_m = (w_ax >= w_ay) ? ((w_ax >= w_az) ? w_ax : w_az)
                                        : ((w_ay >= w_az) ? w_ay : w_az);

            // len = max + (sum of the two smaller) / 4, never exceeds 18 bits
            assign w_sum = 18'(w_ax) + 18'(w_ay) + 18'(w_az);
            assign w_len = 18'(w_m) + ((w_sum - 18'(w_m)) >> 2);

            assign w_dist[gi] = $signed({1'b0, w_len}) - 19'(obj_radius(OBJ));
        end
    endgenerate

    // Nearest object; strict less-than keeps the lower index on ties
    always_comb begin
        w_best = w_dist[0];
        o_obj  = OBJ_BODY;
        for (int i = 1; i < 3; i++) begin
            if (w_dist[i] < w_best) begin
                w_best = w_dist[i];
                o_obj  = obj_e'(2'(i));
            end
        end
    end

    assign o_d = sat16(35'(w_best));

endmodule

// File: rtl/sdf_march_engine.sv
// Fixed-latency sphere tracer for the Kirby scene: N_ITER march steps then
// one shading cycle; three multipliers are shared between stepping and the
// diffuse dot product.
module sdf_march_engine
    import sdf_march_engine_pkg::*;
#(
    parameter int          N_ITER = N_ITER_DEFAULT,
    parameter logic [15:0] EPS    = EPS_DEFAULT,
    parameter logic [15:0] ESCAPE = ESCAPE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [15:0] origin_x,
    input  logic signed [15:0] origin_y,
    input  logic signed [15:0] origin_z,
    input  logic signed [15:0] dir_x,
    input  logic signed [15:0] dir_y,
    input  logic signed [15:0] dir_z,
    input  logic signed [15:0] light_x,
    input  logic signed [15:0] light_y,
    input  logic signed [15:0] light_z,
    output logic               busy,
    output logic               done,
    output logic               surface_hit,
    output logic signed [15:0] intensity,
    output logic        [2:0]  feature_id
);

    localparam int ITER_W = (N_ITER > 2) ? $clog2(N_ITER) : 1;

    state_e              r_state, w_state_next;
    logic signed [15:0]  r_p [3];
    logic signed [15:0]  r_dir [3];
    logic signed [15:0]  r_light [3];
    logic                r_hit, r_miss;
    logic [ITER_W-1:0]   r_iter;
    logic                r_busy, r_done, r_surface_hit;
    logic signed [15:0]  r_intensity;
    feature_e            r_feature_id;

    logic signed [15:0]  w_origin [3];
    logic signed [15:0]  w_dir_in [3];
    logic signed [15:0]  w_light_in [3];
    logic signed [15:0]  w_d;
    obj_e                w_obj;
    logic signed [15:0]  w_mul_a [3];
    logic signed [15:0]  w_mul_b [3];
    logic signed [31:0]  w_prod [3];
    logic signed [15:0]  w_norm [3];
    logic signed [15:0]  w_p_next [3];
    logic signed [16:0]  w_abs [3];
    logic [2:0]          w_escape_ax;
    logic                w_escape, w_hit_now, w_eye, w_shading;
    logic signed [34:0]  w_dot;
    logic signed [15:0]  w_shade;
    feature_e            w_feature;

    assign w_origin   = '{origin_x, origin_y, origin_z};
    assign w_dir_in   = '{dir_x, dir_y, dir_z};
    assign w_light_in = '{light_x, light_y, light_z};

    kirby_sdf u_sdf (
        .i_p_x (r_p[0]),
        .i_p_y (r_p[1]),
        .i_p_z (r_p[2]),
        .o_d   (w_d),
        .o_obj (w_obj)
    );

    assign w_shading = (r_state == ST_SHADE);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_axis
            logic signed [16:0] w_pe, w_rel;
            logic signed [34:0] w_rel_sh;
            logic signed [17:0] w_step;

            // Surface normal: offset from the hit object's centre scaled to unit length
            assign w_rel    = 17'(r_p[gi]) - 17'(obj_centre(w_obj, gi));
            assign w_rel_sh = (w_obj == OBJ_BODY) ? (35'(w_rel) <<< 2) : (35'(w_rel) <<< 3);
            assign w_norm[gi] = sat16(w_rel_sh);

            // Shared multiplier: dir*d while marching, normal*light while shading
            assign w_mul_a[gi] = w_shading ? w_norm[gi] : r_dir[gi];
            assign w_mul_b[gi] = w_shading ? r_light[gi] : w_d;
            assign w_prod[gi]  = w_mul_a[gi] * w_mul_b[gi];

            assign w_step        = w_prod[gi][31:14];
            assign w_p_next[gi]  = sat16(35'(r_p[gi]) + 35'(w_step));

            assign w_pe            = 17'(r_p[gi]);
            assign w_abs[gi]       = w_pe[16] ? -w_pe : w_pe;
            assign w_escape_ax[gi] = (w_abs[gi] > $signed({1'b0, ESCAPE}));
        end
    endgenerate

    assign w_escape  = |w_escape_ax;
    assign w_hit_now = (w_d <= $signed(EPS));

    assign w_dot   = 35'(w_prod[0]) + 35'(w_prod[1]) + 35'(w_prod[2]);
    assign w_shade = sat16(w_dot >>> 14);

    assign w_eye = (r_p[2] < EYE_Z_MAX) &&
                   (w_abs[0] >= 17'(EYE_X_MIN)) && (w_abs[0] <= 17'(EYE_X_MAX)) &&
                   (r_p[1] >= EYE_Y_MIN) && (r_p[1] <= EYE_Y_MAX);

    assign w_feature = (w_obj == OBJ_BODY) ? (w_eye ? FEAT_EYE : FEAT_BODY) : FEAT_FOOT;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next state: start restarts from anywhere, otherwise march then shade once
    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = ST_MARCH;
        end else begin
            case (r_state)
                ST_MARCH: if (r_iter == ITER_W'(N_ITER - 1)) w_state_next = ST_SHADE;
                ST_SHADE: w_state_next = ST_IDLE;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // Ray capture, per-iteration march update and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p           <= '{default: '0};
            r_dir         <= '{default: '0};
            r_light       <= '{default: '0};
            r_hit         <= 1'b0;
            r_miss        <= 1'b0;
            r_iter        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_surface_hit <= 1'b0;
            r_intensity   <= '0;
            r_feature_id  <= FEAT_MISS;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_p     <= w_origin;
                r_dir   <= w_dir_in;
                r_light <= w_light_in;
                r_hit   <= 1'b0;
                r_miss  <= 1'b0;
                r_iter  <= '0;
                r_busy  <= 1'b1;
            end else if (r_state == ST_MARCH) begin
                r_iter <= r_iter + 1'b1;
                // Once hit or escaped, p stays frozen for the rest of the ray
                if (!r_hit && !r_miss) begin
                    if (w_escape)
                        r_miss <= 1'b1;
                    else if (w_hit_now)
                        r_hit <= 1'b1;
                    else
                        r_p <= w_p_next;
                end
            end else if (r_state == ST_SHADE) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                if (r_hit) begin
                    r_surface_hit <= 1'b1;
                    r_intensity   <= w_shade;
                    r_feature_id  <= w_feature;
                end else begin
                    r_surface_hit <= 1'b0;
                    r_intensity   <= '0;
                    r_feature_id  <= FEAT_MISS;
                end
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign surface_hit = r_surface_hit;
    assign intensity   = r_intensity;
    assign feature_id  = r_feature_id;

endmodule
